// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction memory.
package inst_mem_loader_pkg;

    // Instruction memory depth in 32-bit words; the loader and memory must agree.
    localparam int unsigned INST_MEM_SIZE = 64;

    // Word counter width; 2**CNT_W must exceed INST_MEM_SIZE so a full load is countable.
    localparam int unsigned CNT_W = 7;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned BCNT_W     = 2;

    // Word index to byte address: four bytes per instruction word.
    localparam int unsigned ADDR_SHIFT = 2;

    // Loader control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // One instruction-memory write transaction.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_wr_t;

endpackage

// File: rtl/inst_mem_loader_if.sv
// Host byte stream, load control and instruction-memory write port of the loader.
interface inst_mem_loader_if #(
    parameter int unsigned CNT_W = inst_mem_loader_pkg::CNT_W
);
    import inst_mem_loader_pkg::*;

    // Load control from the host.
    logic                 start;
    logic [CNT_W-1:0]     num_words;

    // Byte stream, valid/ready handshake.
    logic                 byte_valid;
    logic [BYTE_W-1:0]    byte_data;
    logic                 byte_ready;

    // Instruction-memory write port.
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;

    // Status back to the host and the CPU pipeline.
    logic                 busy;
    logic                 cpu_stall;
    logic                 done;
    logic                 err;

    // Host / byte source side.
    modport master (
        output start,
        output num_words,
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  busy,
        input  cpu_stall,
        input  done,
        input  err
    );

    // Loader side.
    modport slave (
        input  start,
        input  num_words,
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output busy,
        output cpu_stall,
        output done,
        output err
    );

endinterface

// File: rtl/inst_mem_loader_byte_packer.sv
// Shifts accepted bytes MSB-first into a 32-bit word and flags the byte that completes it.
module inst_mem_loader_byte_packer
    import inst_mem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              word_full_c_o,
    output logic [DATA_W-1:0] word_nxt_c_o
);

    logic [BCNT_W-1:0] cnt_q;
    logic [BCNT_W-1:0] cnt_d;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_d;

    // Next shift-register and byte-count values; clear wins over a byte.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (accept_i) begin
            cnt_d  = cnt_q + BCNT_W'(1);
            word_d = {word_q[DATA_W-BYTE_W-1:0], byte_i};
        end
    end

    // Packer state; the counter wraps to zero after each completed word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    // The word is complete on the edge that accepts its fourth byte.
    assign word_full_c_o = accept_i && !clear_i && (cnt_q == BCNT_W'(3));
    assign word_nxt_c_o  = word_d;

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a program from a byte stream into instruction memory, stalling the CPU meanwhile.
module inst_mem_loader #(
    parameter int unsigned INST_MEM_SIZE = inst_mem_loader_pkg::INST_MEM_SIZE,
    parameter int unsigned CNT_W         = inst_mem_loader_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    inst_mem_loader_if.slave bus
);
    import inst_mem_loader_pkg::*;

    state_e            state_q;
    state_e            state_d;

    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [CNT_W-1:0]  word_idx_q;
    logic [CNT_W-1:0]  word_idx_d;
    logic [CNT_W-1:0]  word_idx_inc;

    logic              err_q;
    logic              err_d;
    logic              byte_ready_q;
    logic              byte_ready_d;
    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;
    logic              mem_we_q;
    logic              mem_we_d;
    mem_wr_t           mem_wr_q;
    mem_wr_t           mem_wr_d;

    logic              accept_c;
    logic              packer_clear_c;
    logic              word_full_c;
    logic [DATA_W-1:0] word_nxt_c;

    // A byte moves only while the registered ready is up, which happens only in LOAD.
    assign accept_c     = bus.byte_valid && byte_ready_q;
    assign word_idx_inc = word_idx_q + CNT_W'(1);

    inst_mem_loader_byte_packer u_packer (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_i       (packer_clear_c),
        .accept_i      (accept_c),
        .byte_i        (bus.byte_data),
        .word_full_c_o (word_full_c),
        .word_nxt_c_o  (word_nxt_c)
    );

    // Next-state, counters, error and registered-output next values.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        word_idx_d     = word_idx_q;
        err_d          = err_q;
        mem_we_d       = 1'b0;
        mem_wr_d       = mem_wr_q;
        packer_clear_c = 1'b0;
        byte_ready_d   = 1'b0;
        busy_d         = 1'b0;
        done_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.num_words == '0) begin
                        state_d = ST_DONE;
                    end else if (bus.num_words > CNT_W'(INST_MEM_SIZE)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        count_d        = bus.num_words;
                        word_idx_d     = '0;
                        err_d          = 1'b0;
                        packer_clear_c = 1'b1;
                        state_d        = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                // Capture the completed word so the strobe lands in WRITE.
                if (word_full_c) begin
                    mem_we_d      = 1'b1;
                    mem_wr_d.addr = ADDR_W'(word_idx_q) << ADDR_SHIFT;
                    mem_wr_d.data = word_nxt_c;
                    state_d       = ST_WRITE;
                end
            end
            ST_WRITE: begin
                word_idx_d = word_idx_inc;
                if (word_idx_inc == count_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered copies of the state being entered.
        byte_ready_d = (state_d == ST_LOAD);
        busy_d       = (state_d == ST_LOAD) || (state_d == ST_WRITE);
        done_d       = (state_d == ST_DONE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Word bookkeeping, sticky error and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            word_idx_q   <= '0;
            err_q        <= 1'b0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wr_q     <= '0;
        end else begin
            count_q      <= count_d;
            word_idx_q   <= word_idx_d;
            err_q        <= err_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mem_we_q     <= mem_we_d;
            mem_wr_q     <= mem_wr_d;
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_wr_q.addr;
    assign bus.mem_wdata  = mem_wr_q.data;
    assign bus.busy       = busy_q;
    assign bus.cpu_stall  = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule
